load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage of the RV32I pipeline. It sits directly upstream of the data RAM and is the only block that drives its address, write and width signals. It turns one load/store request per cycle into RAM accesses, and sign- or zero-extends load data. Misaligned accesses are split into byte-serial RAM accesses, so software never sees the RAM's zero-fill on word-boundary crossings.

Parameters:
None; XLEN and write_width_t come from the shared core package.

Ports:
clock  in  1  core clock; all state updates on rising edge
reset_n  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid && req_ready
req_is_store  in  1  1 = store, 0 = load
req_width  in  write_width_t  access size: write_byte / write_halfword / write_word
req_unsigned  in  1  loads only: zero-extend (LBU/LHU); ignored for word accesses and stores
req_addr  in  XLEN  byte address
req_w_data  in  XLEN  store data, right-justified
resp_valid  out  1  load data or store completion valid this cycle
resp_data  out  XLEN  extended load result; 0 for stores
ram_addr  out  XLEN  RAM byte address
ram_w_data  out  XLEN  RAM write data, right-justified
ram_w_width  out  write_width_t  RAM write width
ram_w_enable  out  1  RAM write strobe
ram_r_data  in  XLEN  RAM read data, one cycle after ram_addr

Behaviour:
- Size N is 1, 2 or 4 bytes. An access is aligned when addr mod N == 0.
- States:
  - IDLE: req_ready = 1.
  - SPLIT: req_ready = 0.
- Aligned request accepted in cycle T:
  - RAM signals are driven combinationally from the req_* signals in T.
  - ram_w_enable = req_is_store.
  - resp_valid = 1 in T+1.
  - Throughput is 1 per cycle; back-to-back requests are legal.
- Misaligned request accepted in cycle T:
  - Latch addr, data, width and unsigned; go to SPLIT.
  - Byte i (0..N-1) is issued in cycle T+i at ram_addr = addr+i, with ram_w_width = write_byte.
  - Address arithmetic is modulo 2^XLEN; 0xFFFFFFFF+1 wraps to 0.
  - Stores: ram_w_data[7:0] = req_w_data[8i+7:8i]; the upper bits are 0.
  - Loads: ram_r_data[7:0] at T+i+1 fills byte i of an assembly register.
  - resp_valid = 1 in T+N; return to IDLE in T+N-1, so a new request can be accepted in T+N.
- Load extension, applied to the assembled or RAM value:
  - byte: bit 7 is replicated unless req_unsigned.
  - halfword: bit 15 is replicated unless req_unsigned.
  - word: passed through unchanged.
- resp_data is combinational from ram_r_data in the response cycle, plus the registered width/unsigned/assembly state.
- Idle outputs, when no request is accepted and not in SPLIT:
  - ram_w_enable = 0.
  - ram_addr = req_addr (harmless read).
  - ram_w_width = write_word.
- Reset (reset_n low at an edge):
  - State returns to IDLE; pending response, assembly register and latched request are cleared.
  - resp_valid = 0 in the following cycle.
- While reset_n is low, ram_w_enable is forced 0 combinationally.
- Reset mid-SPLIT aborts the access: bytes already written stay written, remaining bytes are never written, and no response is produced.
- req_ready is 0 while reset_n is low.
- A request presented while req_ready = 0 is held by upstream (valid/ready handshake) and has no effect.

Decomposition:
- The shared core package gains a typedef lsu_state_t {LSU_IDLE, LSU_SPLIT} and a function that returns the byte count N for a write_width_t; both are reused by the decode stage.
- One natural sub-module, load_extender: combinational width/sign extension, shared with a future uncached I/O path.

Test Plan:
- Memory word 0x10 = 0xDEADBEEF. LW 0x10 accepted at T -> resp_valid at T+1, resp_data 0xDEADBEEF.
- Same memory:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - Issued on consecutive cycles -> responses on consecutive cycles.
- Words 0x0C = 0x44332211 and 0x10 = 0x88776655. LW 0x0E -> req_ready low for 3 cycles, four byte reads at 0x0E..0x11, resp_data 0x66554433 at T+4.
- SH 0x03 with data 0x0000ABCD -> byte writes 0xCD@0x03 (T) and 0xAB@0x04 (T+1). Then LW 0x00 and LW 0x04 show only those bytes changed.
- SW 0x0000_0001 data 0x11223344 with reset_n pulled low at T+2 -> bytes 0x44@0x01 and 0x33@0x02 written, 0x03/0x04 unchanged, no resp_valid, req_ready = 1 after reset.
- LB 0xFFFFFFFF (in depth-aliased RAM) and misaligned LH 0xFFFFFFFF -> second byte address wraps to 0x00000000.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared core types for the RV32I pipeline.
// Access widths, LSU state encoding and access-size helpers.
package load_store_unit_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      write_byte     = 2'd0,
      write_halfword = 2'd1,
      write_word     = 2'd2
   } write_width_t;

   typedef enum logic {
      LSU_IDLE  = 1'b0,
      LSU_SPLIT = 1'b1
   } lsu_state_t;

   // Number of bytes moved by an access of the given width.
   function automatic logic [2:0] width_bytes(input write_width_t w);
      logic [2:0] n;
      case (w)
         write_byte:     n = 3'd1;
         write_halfword: n = 3'd2;
         default:        n = 3'd4;
      endcase
      return n;
   endfunction

   // True when the address is not a multiple of the access size.
   function automatic logic is_misaligned(
      input logic [XLEN-1:0] a,
      input write_width_t    w
   );
      logic m;
      case (w)
         write_halfword: m = a[0];
         write_word:     m = |a[1:0];
         default:        m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/load_store_unit_extender.sv
// Load result extension.
// Sign- or zero-extends a right-justified byte/halfword.
module load_extender
   import load_store_unit_pkg::*;
(
   input  logic [XLEN-1:0] i_data,
   input  write_width_t    i_width,
   input  logic            i_unsigned,
   output logic [XLEN-1:0] o_data
);

   logic w_fill_b;
   logic w_fill_h;

   assign w_fill_b = i_data[7] & ~i_unsigned;
   assign w_fill_h = i_data[15] & ~i_unsigned;

   // Select the extension for the access width; words pass through.
   always_comb begin
      o_data = i_data;
      case (i_width)
         write_byte:
            o_data = {{(XLEN-8){w_fill_b}}, i_data[7:0]};
         write_halfword:
            o_data = {{(XLEN-16){w_fill_h}}, i_data[15:0]};
         default:
            o_data = i_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: drives the data RAM.
// Misaligned accesses are split into byte-serial RAM accesses.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  write_width_t    req_width,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_w_data,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic [XLEN-1:0] ram_addr,
   output logic [XLEN-1:0] ram_w_data,
   output write_width_t    ram_w_width,
   output logic            ram_w_enable,
   input  logic [XLEN-1:0] ram_r_data
);

   lsu_state_t      r_state;
   lsu_state_t      w_state_nxt;

   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_data;
   logic            r_is_store;
   logic [1:0]      r_idx;
   logic [XLEN-1:0] r_asm;

   logic            r_resp_valid;
   logic            r_resp_store;
   logic            r_resp_split;
   write_width_t    r_resp_width;
   logic            r_resp_unsigned;
   logic [1:0]      r_resp_last;

   logic            w_ready;
   logic            w_accept;
   logic            w_misaligned;
   logic [2:0]      w_req_n;
   logic [1:0]      w_req_last;
   logic            w_last;
   logic            w_we;
   logic [1:0]      w_idx_m1;
   logic [XLEN-1:0] w_split_word;
   logic [XLEN-1:0] w_rbyte;
   logic [XLEN-1:0] w_asm_in;
   logic [XLEN-1:0] w_asm_final;
   logic [XLEN-1:0] w_raw;
   logic [XLEN-1:0] w_ext;

   assign w_ready      = reset_n & (r_state == LSU_IDLE);
   assign req_ready    = w_ready;
   assign w_accept     = req_valid & w_ready;
   assign w_misaligned = is_misaligned(req_addr, req_width);
   assign w_req_n      = width_bytes(req_width);
   assign w_req_last   = w_req_n[1:0] - 2'd1;
   assign w_last       = (r_idx == r_resp_last);
   assign w_idx_m1     = r_idx - 2'd1;

   // Store byte for the current split step.
   assign w_split_word = r_data >> {r_idx, 3'b000};

   // Incoming read byte, placed where the split step expects it.
   assign w_rbyte  = {{(XLEN-8){1'b0}}, ram_r_data[7:0]};
   assign w_asm_in = w_rbyte << {w_idx_m1, 3'b000};

   // Last byte of a split load is taken straight from the RAM.
   assign w_asm_final = r_asm | (w_rbyte << {r_resp_last, 3'b000});

   // A reset in progress must never write the RAM.
   assign ram_w_enable = w_we & reset_n;

   // Next-state and RAM-side drive.
   always_comb begin
      w_state_nxt = r_state;
      ram_addr    = req_addr;
      ram_w_data  = '0;
      ram_w_width = write_word;
      w_we        = 1'b0;
      unique case (r_state)
         LSU_IDLE: begin
            if (w_accept) begin
               w_we = req_is_store;
               if (w_misaligned) begin
                  ram_w_width = write_byte;
                  ram_w_data  = {{(XLEN-8){1'b0}},
                                 req_w_data[7:0]};
                  w_state_nxt = LSU_SPLIT;
               end else begin
                  ram_w_width = req_width;
                  ram_w_data  = req_w_data;
               end
            end
         end
         LSU_SPLIT: begin
            ram_addr    = r_addr + {{(XLEN-2){1'b0}}, r_idx};
            ram_w_width = write_byte;
            ram_w_data  = {{(XLEN-8){1'b0}},
                           w_split_word[7:0]};
            w_we        = r_is_store;
            if (w_last) begin
               w_state_nxt = LSU_IDLE;
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= LSU_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch a misaligned request and step through its bytes.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_addr     <= '0;
         r_data     <= '0;
         r_is_store <= 1'b0;
         r_idx      <= 2'd0;
      end else if (w_accept && w_misaligned) begin
         r_addr     <= req_addr;
         r_data     <= req_w_data;
         r_is_store <= req_is_store;
         r_idx      <= 2'd1;
      end else if (r_state == LSU_SPLIT) begin
         r_idx <= r_idx + 2'd1;
      end
   end

   // Collect split-load bytes as they return from the RAM.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_asm <= '0;
      end else if (w_accept && w_misaligned) begin
         r_asm <= '0;
      end else if (r_state == LSU_SPLIT) begin
         r_asm <= r_asm | w_asm_in;
      end
   end

   // Response bookkeeping: width/sign held for the response cycle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_resp_valid    <= 1'b0;
         r_resp_store    <= 1'b0;
         r_resp_split    <= 1'b0;
         r_resp_width    <= write_word;
         r_resp_unsigned <= 1'b0;
         r_resp_last     <= 2'd0;
      end else begin
         r_resp_valid <= (w_accept & ~w_misaligned) |
                         ((r_state == LSU_SPLIT) & w_last);
         if (w_accept) begin
            r_resp_store    <= req_is_store;
            r_resp_split    <= w_misaligned;
            r_resp_width    <= req_width;
            r_resp_unsigned <= req_unsigned;
            r_resp_last     <= w_req_last;
         end
      end
   end

   assign w_raw = r_resp_split ? w_asm_final : ram_r_data;

   load_extender u_ext (
      .i_data     (w_raw),
      .i_width    (r_resp_width),
      .i_unsigned (r_resp_unsigned),
      .o_data     (w_ext)
   );

   assign resp_valid = r_resp_valid;
   assign resp_data  = (r_resp_valid && !r_resp_store) ? w_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a small depth-aliased RAM.
// Expected responses are queued on issue and checked by a monitor.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_is_store = 1'b0;
   logic         req_unsigned = 1'b0;
   write_width_t req_width = write_word;
   logic [31:0]  req_addr = '0;
   logic [31:0]  req_w_data = '0;
   logic         req_ready;
   logic         resp_valid;
   logic [31:0]  resp_data;
   logic [31:0]  ram_addr;
   logic [31:0]  ram_w_data;
   write_width_t ram_w_width;
   logic         ram_w_enable;
   logic [31:0]  ram_r_data;

   logic [31:0]  mem [0:15] = '{default: 32'h0};
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      string       name;
   } exp_t;

   exp_t sb[$];

   load_store_unit dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_width    (req_width),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_w_data   (req_w_data),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .ram_addr     (ram_addr),
      .ram_w_data   (ram_w_data),
      .ram_w_width  (ram_w_width),
      .ram_w_enable (ram_w_enable),
      .ram_r_data   (ram_r_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // RAM: right-justified read with zero-fill past the word, byte-lane writes.
   always @(posedge clock) begin
      logic [31:0] t;
      int          off;
      off = 8 * int'(ram_addr[1:0]);
      ram_r_data <= mem[ram_addr[5:2]] >> off;
      if (ram_w_enable) begin
         t = mem[ram_addr[5:2]];
         case (ram_w_width)
            write_byte:     t[off +: 8]  = ram_w_data[7:0];
            write_halfword: t[off +: 16] = ram_w_data[15:0];
            default:        t = ram_w_data;
         endcase
         mem[ram_addr[5:2]] <= t;
      end
   end

   function automatic void check(string name, logic [31:0] act,
                                 logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: every response must match the head of the scoreboard.
   always @(negedge clock) begin
      exp_t e;
      if (resp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected resp_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check({e.name, " data"}, resp_data, e.data);
            check({e.name, " cycle"}, cyc, e.cyc);
         end
      end
   end

   // Issue one request from a negedge; returns at the negedge after acceptance.
   task automatic send(string name, logic st, write_width_t w, logic u,
                       logic [31:0] a, logic [31:0] d,
                       logic [31:0] exp, int lat);
      int waited = 0;
      req_valid    = 1'b1;
      req_is_store = st;
      req_width    = w;
      req_unsigned = u;
      req_addr     = a;
      req_w_data   = d;
      #1;
      while (!req_ready && waited < 20) begin
         @(negedge clock);
         #1;
         waited++;
      end
      if (!req_ready) begin
         check({name, " accept timeout"}, 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      check({name, " addr"}, ram_addr, a);
      check({name, " wen"}, {31'b0, ram_w_enable}, {31'b0, st});
      if (lat > 0) sb.push_back('{data: exp, cyc: cyc + lat, name: name});
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: a store request presented must have no effect.
      req_valid    = 1'b1;
      req_is_store = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check("rst ready", {31'b0, req_ready}, 32'd0);
      check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst wen", {31'b0, ram_w_enable}, 32'd0);
      req_valid    = 1'b0;
      req_is_store = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("post-rst ready", {31'b0, req_ready}, 32'd1);
      @(negedge clock);
      check("post-rst resp_valid", {31'b0, resp_valid}, 32'd0);

      // Aligned accesses, back-to-back.
      send("SW10", 1, write_word, 0, 32'h10, 32'hDEADBEEF, 32'h0, 1);
      send("LW10", 0, write_word, 0, 32'h10, 0, 32'hDEADBEEF, 1);
      send("LB13", 0, write_byte, 0, 32'h13, 0, 32'hFFFFFFDE, 1);
      send("LBU13", 0, write_byte, 1, 32'h13, 0, 32'h000000DE, 1);
      send("LH12", 0, write_halfword, 0, 32'h12, 0, 32'hFFFFDEAD, 1);

      // Misaligned word load crossing a word boundary.
      send("SW0C", 1, write_word, 0, 32'h0C, 32'h44332211, 32'h0, 1);
      send("SW10b", 1, write_word, 0, 32'h10, 32'h88776655, 32'h0, 1);
      send("LW0E", 0, write_word, 0, 32'h0E, 0, 32'h66554433, 4);
      for (int i = 1; i < 4; i++) begin
         #1;
         check("LW0E split ready", {31'b0, req_ready}, 32'd0);
         check("LW0E split addr", ram_addr, 32'h0E + i);
         check("LW0E split width", {30'b0, ram_w_width},
               {30'b0, write_byte});
         @(negedge clock);
      end
      #1;
      check("LW0E ready again", {31'b0, req_ready}, 32'd1);
      @(negedge clock);

      send("LHU0D", 0, write_halfword, 1, 32'h0D, 0, 32'h00003322, 2);
      send("LH0F", 0, write_halfword, 0, 32'h0F, 0, 32'h00005544, 2);

      // Misaligned halfword store.
      send("SW00", 1, write_word, 0, 32'h00, 32'h03020100, 32'h0, 1);
      send("SW04", 1, write_word, 0, 32'h04, 32'h07060504, 32'h0, 1);
      send("SH03", 1, write_halfword, 0, 32'h03, 32'h0000ABCD, 32'h0, 2);
      #1;
      check("SH03 byte1 addr", ram_addr, 32'h04);
      check("SH03 byte1 data", ram_w_data, 32'h000000AB);
      check("SH03 byte1 wen", {31'b0, ram_w_enable}, 32'd1);
      @(negedge clock);
      send("LW00", 0, write_word, 0, 32'h00, 0, 32'hCD020100, 1);
      send("LW04", 0, write_word, 0, 32'h04, 0, 32'h070605AB, 1);

      // Reset in the middle of a split store.
      send("SW01", 1, write_word, 0, 32'h01, 32'h11223344, 32'h0, 0);
      #1;
      check("SW01 byte1 addr", ram_addr, 32'h02);
      check("SW01 byte1 wen", {31'b0, ram_w_enable}, 32'd1);
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      check("SW01 rst wen", {31'b0, ram_w_enable}, 32'd0);
      check("SW01 rst ready", {31'b0, req_ready}, 32'd0);
      @(negedge clock);
      check("SW01 rst resp_valid", {31'b0, resp_valid}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      check("SW01 no resp", {31'b0, resp_valid}, 32'd0);
      #1;
      check("SW01 ready after rst", {31'b0, req_ready}, 32'd1);
      @(negedge clock);
      send("LW00r", 0, write_word, 0, 32'h00, 0, 32'hCD334400, 1);
      send("LW04r", 0, write_word, 0, 32'h04, 0, 32'h070605AB, 1);

      // Address wrap at the top of the address space.
      send("SW3C", 1, write_word, 0, 32'h3C, 32'h80AABBCC, 32'h0, 1);
      send("SB00", 1, write_byte, 0, 32'h00, 32'h0000009A, 32'h0, 1);
      send("LBtop", 0, write_byte, 0, 32'hFFFFFFFF, 0, 32'hFFFFFF80, 1);
      send("LHtop", 0, write_halfword, 0, 32'hFFFFFFFF, 0,
           32'hFFFF9A80, 2);
      #1;
      check("LHtop wrap addr", ram_addr, 32'h00000000);
      @(negedge clock);

      repeat (5) @(negedge clock);
      check("scoreboard drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
